mem_data_responder: RTL and testbench

Memory-side responder for the CPU's data load/store port. It accepts one request at a time over a valid/ready handshake and executes byte, halfword or word reads and writes against an internal word array. It returns a registered response after a fixed, parameterised latency. It sits opposite the load/store stage, which acts as initiator, and replaces the zero-latency data path with a realistic slave so the core can be hardened against wait states.

---
 rtl/mem_resp_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_data_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_data_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - access-size encodings, FSM states and type legality for mem_data_responder
package mem_resp_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Stores only exist in signed-size encodings; loads also allow the unsigned ones.
  function automatic logic type_legal(input logic wr, input logic [2:0] typ);
    logic base_ok;
    base_ok = (typ == MEM_B) || (typ == MEM_H) || (typ == MEM_W);
    if (wr) return base_ok;
    return base_ok || (typ == MEM_BU) || (typ == MEM_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load extraction/extension and store byte-lane merge
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  typ,
  input  logic [1:0]  lane,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (typ)
      MEM_B:   load_data = {{24{sel_byte[7]}}, sel_byte};
      MEM_BU:  load_data = {24'h0, sel_byte};
      MEM_H:   load_data = {{16{sel_half[15]}}, sel_half};
      MEM_HU:  load_data = {16'h0, sel_half};
      default: load_data = word;
    endcase

    store_word = word;
    case (typ)
      MEM_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      MEM_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_data_responder.sv
// rtl/mem_data_responder.sv - fixed-latency load/store responder; MEM_RESP_ERR_EN enables error checks
module mem_data_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  logic        wr_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        a_wr;
  logic [2:0]  a_type;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] off;
  logic [IDX_W-1:0] idx;
  logic        legal;
  logic [2:0]  eff_type;
  logic [1:0]  eff_lane;
  logic        acc_err;
  logic [31:0] old_word;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        unused_off_bits;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the access commits on the accept edge, so it must use the live request.
  always_comb begin
    a_wr    = (state_q == IDLE) ? req_wr    : wr_q;
    a_type  = (state_q == IDLE) ? req_type  : type_q;
    a_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    a_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  end

  assign off             = a_addr - ADDR_BASE;
  assign idx             = off[IDX_W+1:2];
  assign legal           = type_legal(a_wr, a_type);
  assign eff_type        = legal ? a_type : MEM_W;
  assign unused_off_bits = ^{off[31:IDX_W+2], off[1:0]};

  always_comb begin
    case (eff_type)
      MEM_B, MEM_BU: eff_lane = a_addr[1:0];
      MEM_H, MEM_HU: eff_lane = {a_addr[1], 1'b0};
      default:       eff_lane = 2'b00;
    endcase
  end

`ifdef MEM_RESP_ERR_EN
  logic misaligned;
  logic out_of_range;
  assign misaligned   = (((eff_type == MEM_H) || (eff_type == MEM_HU)) && a_addr[0]) ||
                        ((eff_type == MEM_W) && (a_addr[1:0] != 2'b00));
  assign out_of_range = |off[31:IDX_W+2];
  assign acc_err      = !legal || misaligned || out_of_range;
`else
  assign acc_err = 1'b0;
`endif

  assign old_word = mem[idx];

  mem_lane_align u_align (
    .word       (old_word),
    .wdata      (a_wdata),
    .typ        (eff_type),
    .lane       (eff_lane),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rstn && commit && a_wr && !acc_err) mem[idx] <= store_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      type_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        wr_q    <= req_wr;
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) rdata_q <= (a_wr || acc_err) ? 32'h0 : load_data;
    end
  end

`ifdef MEM_RESP_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       err_q <= 1'b0;
    else if (commit) err_q <= acc_err;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_data_responder.sv
// tb/tb_mem_data_responder.sv - directed vector bench for mem_data_responder (LATENCY 2 and 1)
module tb_mem_data_responder;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        req_valid_1, req_ready_1, req_wr_1, rsp_valid_1, rsp_ready_1, rsp_err_1;
  logic [2:0]  req_type_1;
  logic [31:0] req_addr_1, req_wdata_1, rsp_rdata_1;

  int checks   = 0;
  int failures = 0;

  mem_data_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_BASE(32'h8000_0000)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_data_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .ADDR_BASE(32'h8000_0000)) dut1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_wr(req_wr_1), .req_type(req_type_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.typ = typ; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One complete transaction; lat counts edges from the accept edge (inclusive) to rsp_valid.
  task automatic txn(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                     output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_type = typ; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check32("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); @(negedge clk); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] word14_final;
  logic [31:0] s_addr  [8];
  logic [31:0] s_wdata [8];
  logic [31:0] s_exp   [8];
  logic        s_wr    [8];

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_type = MEM_W; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_1 = 1'b0; req_wr_1 = 1'b0; req_type_1 = MEM_W; req_addr_1 = '0; req_wdata_1 = '0;
    rsp_ready_1 = 1'b0;

    add(1, MEM_W,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    add(0, MEM_W,  32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    add(1, MEM_B,  32'h8000_0011, 32'h0000_0055, 32'h0000_0000, 0);
    add(0, MEM_W,  32'h8000_0010, 32'h0,         32'hDEAD_55EF, 0);
    add(0, MEM_B,  32'h8000_0013, 32'h0,         32'hFFFF_FFDE, 0);
    add(0, MEM_BU, 32'h8000_0013, 32'h0,         32'h0000_00DE, 0);
    add(0, MEM_H,  32'h8000_0012, 32'h0,         32'hFFFF_DEAD, 0);
    add(0, MEM_HU, 32'h8000_0010, 32'h0,         32'h0000_55EF, 0);
    add(1, MEM_W,  32'h8000_0014, 32'h1122_3344, 32'h0000_0000, 0);
    add(1, MEM_H,  32'h8000_0016, 32'hAAAA_8001, 32'h0000_0000, 0);
    add(0, MEM_W,  32'h8000_0014, 32'h0,         32'h8001_3344, 0);
    add(0, MEM_H,  32'h8000_0016, 32'h0,         32'hFFFF_8001, 0);
    add(0, MEM_B,  32'h8000_0015, 32'h0,         32'h0000_0033, 0);
    if (ERR_EN) begin
      add(0, MEM_W,  32'h8000_0012, 32'h0,         32'h0, 1);
      add(0, MEM_W,  32'h8000_1010, 32'h0,         32'h0, 1);
      add(1, MEM_W,  32'h7FFF_FFFC, 32'h0,         32'h0, 1);
      add(0, 3'd3,   32'h8000_0010, 32'h0,         32'h0, 1);
      add(1, MEM_W,  32'h8000_0016, 32'hCAFE_F00D, 32'h0, 1);
      add(0, MEM_W,  32'h8000_0014, 32'h0,         32'h8001_3344, 0);
      add(0, MEM_H,  32'h8000_0011, 32'h0,         32'h0, 1);
      word14_final = 32'h8001_3344;
    end else begin
      add(0, MEM_W,  32'h8000_0012, 32'h0,         32'hDEAD_55EF, 0);
      add(0, MEM_W,  32'h8000_1010, 32'h0,         32'hDEAD_55EF, 0);
      add(1, MEM_W,  32'h7FFF_FFFC, 32'h0,         32'h0, 0);
      add(0, 3'd3,   32'h8000_0010, 32'h0,         32'hDEAD_55EF, 0);
      add(1, MEM_W,  32'h8000_0016, 32'hCAFE_F00D, 32'h0, 0);
      add(0, MEM_W,  32'h8000_0014, 32'h0,         32'hCAFE_F00D, 0);
      add(0, MEM_H,  32'h8000_0011, 32'h0,         32'h0000_55EF, 0);
      word14_final = 32'hCAFE_F00D;
    end

    repeat (2) @(negedge clk);
    check32("reset_req_ready", {31'h0, req_ready}, 32'd1);
    check32("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check32("reset_rsp_rdata", rsp_rdata, 32'd0);
    check32("reset_rsp_err",   {31'h0, rsp_err}, 32'd0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      txn(vecs[i].wr, vecs[i].typ, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check32($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check32($sformatf("vec%0d_latency", i), lat, 32'd2);
    end

    // Backpressure: response held 5 cycles while the next request waits.
    begin
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_type = MEM_W; req_addr = 32'h8000_0010; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h8000_0014;
      guard = 0;
      while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
      for (int k = 0; k < 5; k++) begin
        check32($sformatf("bp_rdata_%0d", k), rsp_rdata, 32'hDEAD_55EF);
        check32($sformatf("bp_req_ready_%0d", k), {31'h0, req_ready}, 32'd0);
        check32($sformatf("bp_rsp_valid_%0d", k), {31'h0, rsp_valid}, 32'd1);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check32("bp_idle_after_hs", {31'h0, req_ready}, 32'd1);
      check32("bp_valid_cleared", {31'h0, rsp_valid}, 32'd0);
      @(negedge clk);
      check32("bp_second_accepted", {31'h0, req_ready}, 32'd0);
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
      check32("bp_second_rdata", rsp_rdata, word14_final);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end

    // Reset during WAIT drops the pending store.
    txn(1, MEM_W, 32'h8000_0020, 32'h0BAD_F00D, rd, er, lat);
    txn(0, MEM_W, 32'h8000_0020, 32'h0, rd, er, lat);
    check32("pre_reset_lw", rd, 32'h0BAD_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_type = MEM_W; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check32("in_wait_ready", {31'h0, req_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    check32("mid_reset_req_ready", {31'h0, req_ready}, 32'd1);
    check32("mid_reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check32("mid_reset_rsp_rdata", rsp_rdata, 32'd0);
    check32("mid_reset_rsp_err",   {31'h0, rsp_err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    txn(0, MEM_W, 32'h8000_0020, 32'h0, rd, er, lat);
    check32("post_reset_lw", rd, 32'h0BAD_F00D);

    // LATENCY=1: back-to-back stream, one response every 2 cycles.
    for (int i = 0; i < 8; i++) begin
      s_addr[i]  = 32'h8000_0000 + 32'(4 * (i % 4));
      s_wdata[i] = 32'hA500_0000 | 32'((i % 4) * 32'h111);
      s_wr[i]    = (i < 4);
      s_exp[i]   = (i < 4) ? 32'h0 : s_wdata[i];
    end
    begin
      int aidx, ridx, last;
      aidx = 0; ridx = 0; last = 0;
      rsp_ready_1 = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(negedge clk);
        if (rsp_valid_1) begin
          check32($sformatf("l1_rdata_%0d", ridx), rsp_rdata_1, s_exp[ridx]);
          if (ridx > 0) check32($sformatf("l1_interval_%0d", ridx), cyc - last, 32'd2);
          last = cyc;
          ridx++;
          if (ridx == 8) break;
        end
        if (req_ready_1) begin
          if (aidx < 8) begin
            req_valid_1 = 1'b1; req_wr_1 = s_wr[aidx]; req_type_1 = MEM_W;
            req_addr_1 = s_addr[aidx]; req_wdata_1 = s_wdata[aidx];
            aidx++;
          end else begin
            req_valid_1 = 1'b0;
          end
        end
      end
      req_valid_1 = 1'b0;
      check32("l1_resp_count", ridx, 32'd8);
      @(negedge clk);
      rsp_ready_1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
